// File: rtl/fog_pkg.sv
// Shared constants, state encoding and elaboration helpers for the FogZip Morton encoder.
package fog_pkg;

  localparam int MAX_DEPTH_DEF = 9;
  localparam logic signed [15:0] BB_MIN_DEF = -16'sd20000;
  localparam logic signed [15:0] BB_MAX_DEF = 16'sd20000;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_READ      = 4'd1;
  localparam logic [3:0] ST_COMPUTE   = 4'd2;
  localparam logic [3:0] ST_WRITEBACK = 4'd3;
  localparam logic [3:0] ST_MEMWR     = 4'd4;
  localparam logic [3:0] ST_MEMWAIT   = 4'd5;
  localparam logic [3:0] ST_NEXT      = 4'd6;
  localparam logic [3:0] ST_HEADER    = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  localparam logic [1:0] MK_DATA  = 2'd0;
  localparam logic [1:0] MK_FLUSH = 2'd1;
  localparam logic [1:0] MK_HDR   = 2'd2;

  localparam logic [31:0] HDR_ADDR  = 32'd0;
  localparam logic [31:0] DATA_BASE = 32'd8;
  localparam logic [31:0] FLUSH_PAD = 32'hFFFF_FFFF;

  // Smallest right shift that squeezes the box extent into 2^depth cells.
  function automatic int calc_shift(input int range, input int depth);
    int s;
    s = 31;
    for (int i = 31; i >= 0; i--) begin
      if ((range >> i) < (1 << depth)) s = i;
    end
    return s;
  endfunction

  localparam int CODE_W = 3 * MAX_DEPTH_DEF;
  localparam int SHIFT  = calc_shift(int'(BB_MAX_DEF) - int'(BB_MIN_DEF), MAX_DEPTH_DEF);

  // Internal states collapse onto the externally visible status codes.
  function automatic logic [2:0] status_code(input logic [3:0] st);
    logic [2:0] c;
    case (st)
      ST_IDLE:                c = 3'd0;
      ST_READ:                c = 3'd1;
      ST_COMPUTE:             c = 3'd2;
      ST_WRITEBACK:           c = 3'd3;
      ST_MEMWR, ST_MEMWAIT:   c = 3'd4;
      ST_NEXT:                c = 3'd5;
      ST_HEADER:              c = 3'd6;
      default:                c = 3'd7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fog_morton.sv
// Combinational bounding-box check, per-axis quantisation, 3-way bit interleave and 16-bit node tag.
module fog_morton
  import fog_pkg::*;
#(
  parameter logic signed [15:0] BB_MIN_X  = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MIN_Y  = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MIN_Z  = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MAX_X  = BB_MAX_DEF,
  parameter logic signed [15:0] BB_MAX_Y  = BB_MAX_DEF,
  parameter logic signed [15:0] BB_MAX_Z  = BB_MAX_DEF,
  parameter int                 MAX_DEPTH = MAX_DEPTH_DEF
) (
  input  logic signed [15:0]        i_x,
  input  logic signed [15:0]        i_y,
  input  logic signed [15:0]        i_z,
  output logic                      o_in_box,
  output logic [3*MAX_DEPTH-1:0]    o_code,
  output logic [15:0]               o_tag
);

  localparam int CW      = 3 * MAX_DEPTH;
  localparam int RANGE_X = int'(BB_MAX_X) - int'(BB_MIN_X);
  localparam int RANGE_Y = int'(BB_MAX_Y) - int'(BB_MIN_Y);
  localparam int RANGE_Z = int'(BB_MAX_Z) - int'(BB_MIN_Z);
  localparam int RANGE_XY = (RANGE_X > RANGE_Y) ? RANGE_X : RANGE_Y;
  localparam int RANGE    = (RANGE_XY > RANGE_Z) ? RANGE_XY : RANGE_Z;
  localparam int LSHIFT   = calc_shift(RANGE, MAX_DEPTH);

  logic [16:0]          w_dx, w_dy, w_dz;
  logic [MAX_DEPTH-1:0] w_cx, w_cy, w_cz;

  assign o_in_box = (i_x >= BB_MIN_X) && (i_x <= BB_MAX_X) &&
                    (i_y >= BB_MIN_Y) && (i_y <= BB_MAX_Y) &&
                    (i_z >= BB_MIN_Z) && (i_z <= BB_MAX_Z);

  // 17-bit offsets are non-negative whenever the point is inside the box.
  assign w_dx = {i_x[15], i_x} - {BB_MIN_X[15], BB_MIN_X};
  assign w_dy = {i_y[15], i_y} - {BB_MIN_Y[15], BB_MIN_Y};
  assign w_dz = {i_z[15], i_z} - {BB_MIN_Z[15], BB_MIN_Z};

  assign w_cx = MAX_DEPTH'(w_dx >> LSHIFT);
  assign w_cy = MAX_DEPTH'(w_dy >> LSHIFT);
  assign w_cz = MAX_DEPTH'(w_dz >> LSHIFT);

  always_comb begin
    o_code = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      o_code[3*i+2] = w_cx[i];
      o_code[3*i+1] = w_cy[i];
      o_code[3*i]   = w_cz[i];
    end
  end

  // Left-align the code in 32 bits so short codes come out zero-padded on the right.
  assign o_tag = 16'((32'(o_code) << (32 - CW)) >> 16);

endmodule

// File: rtl/ext_fog.sv
// ALFA extension: Morton-encodes each frame point, writes back a node tag and packs codes into EXT_MEM words plus a header.
module ext_fog
  import fog_pkg::*;
#(
  parameter int                 NUMBER_NODES        = 100000,
  parameter int                 PARALLEL_PROCESSING = 1,
  parameter int                 COMPRESSION         = 1,
  parameter logic signed [15:0] BB_MIN_X            = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MIN_Y            = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MIN_Z            = BB_MIN_DEF,
  parameter logic signed [15:0] BB_MAX_X            = BB_MAX_DEF,
  parameter logic signed [15:0] BB_MAX_Y            = BB_MAX_DEF,
  parameter logic signed [15:0] BB_MAX_Z            = BB_MAX_DEF,
  parameter int                 MAX_DEPTH           = MAX_DEPTH_DEF
) (
  input  logic               i_SYSTEM_clk,
  input  logic               i_SYSTEM_rst,
  input  logic               EXT_enable,
  input  logic [18:0]        EXT_PCSize,
  output logic               EXT_readReady,
  output logic [18:0]        EXT_readID,
  input  logic               EXT_readValid,
  input  logic signed [15:0] EXT_pointX,
  input  logic signed [15:0] EXT_pointY,
  input  logic signed [15:0] EXT_pointZ,
  input  logic [15:0]        EXT_readCustomField,
  output logic               EXT_writeValid,
  output logic [18:0]        EXT_writeID,
  output logic [15:0]        EXT_writeCustomField,
  input  logic               EXT_writeReady,
  output logic               EXT_doneProcessing,
  output logic [31:0]        EXT_status,
  output logic [31:0]        EXT_MEM_writeAddress,
  output logic [63:0]        EXT_MEM_writePayload,
  output logic               EXT_MEM_initWriteTxn,
  input  logic               EXT_MEM_writeTxnDone,
  output logic [31:0]        EXT_MEM_readAddress,
  output logic               EXT_MEM_initReadTxn,
  input  logic [63:0]        EXT_MEM_readPayload,
  input  logic               EXT_MEM_readTxnDone,
  input  logic               EXT_MEM_error
);

  localparam int          CW      = 3 * MAX_DEPTH;
  localparam logic [31:0] NODES_U = NUMBER_NODES;

  logic [3:0]         r_state;
  logic [18:0]        r_idx, r_enc, r_pcsize;
  logic signed [15:0] r_x, r_y, r_z;
  logic [CW-1:0]      r_code, r_pend;
  logic               r_pend_vld, r_err;
  logic [15:0]        r_tag;
  logic [31:0]        r_addr;
  logic [63:0]        r_word;
  logic [1:0]         r_kind;

  logic               w_in_box, w_idx_ok;
  logic [CW-1:0]      w_code;
  logic [15:0]        w_tag;
  logic [18:0]        w_idx_nxt;
  logic               w_unused;

  fog_morton #(
    .BB_MIN_X (BB_MIN_X), .BB_MIN_Y (BB_MIN_Y), .BB_MIN_Z (BB_MIN_Z),
    .BB_MAX_X (BB_MAX_X), .BB_MAX_Y (BB_MAX_Y), .BB_MAX_Z (BB_MAX_Z),
    .MAX_DEPTH(MAX_DEPTH)
  ) u_morton (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .o_in_box(w_in_box),
    .o_code  (w_code),
    .o_tag   (w_tag)
  );

  assign w_idx_ok  = {13'b0, r_idx} < NODES_U;
  assign w_idx_nxt = r_idx + 19'd1;

  assign EXT_readReady        = (r_state == ST_READ);
  assign EXT_readID           = r_idx;
  assign EXT_writeValid       = (r_state == ST_WRITEBACK);
  assign EXT_writeID          = r_idx;
  assign EXT_writeCustomField = r_tag;
  assign EXT_doneProcessing   = (r_state == ST_DONE);
  assign EXT_status           = {r_idx, 9'b0, r_err, status_code(r_state)};
  assign EXT_MEM_writeAddress = r_addr;
  assign EXT_MEM_writePayload = r_word;
  assign EXT_MEM_initWriteTxn = (r_state == ST_MEMWR);
  assign EXT_MEM_readAddress  = 32'd0;
  assign EXT_MEM_initReadTxn  = 1'b0;

  // Read channel and lane count are not consumed by the single-lane write-only datapath.
  assign w_unused = ^{EXT_readCustomField, EXT_MEM_readPayload, EXT_MEM_readTxnDone,
                      PARALLEL_PROCESSING[0]};

  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_enc      <= '0;
      r_pcsize   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_code     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_word     <= '0;
      r_kind     <= MK_DATA;
    end else begin
      case (r_state)
        ST_IDLE: if (EXT_enable) begin
          r_idx      <= '0;
          r_enc      <= '0;
          r_addr     <= DATA_BASE;
          r_pcsize   <= EXT_PCSize;
          r_pend_vld <= 1'b0;
          r_err      <= 1'b0;
          r_state    <= (EXT_PCSize == 19'd0) ? ST_HEADER : ST_READ;
        end
        ST_READ: if (EXT_readValid) begin
          r_x     <= EXT_pointX;
          r_y     <= EXT_pointY;
          r_z     <= EXT_pointZ;
          r_state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (w_in_box && w_idx_ok) begin
            r_code  <= w_code;
            r_tag   <= w_tag;
            r_state <= ST_WRITEBACK;
          end else begin
            r_state <= ST_NEXT;
          end
        end
        ST_WRITEBACK: if (EXT_writeReady) begin
          r_enc <= r_enc + 19'd1;
          if (COMPRESSION == 0) begin
            r_word  <= {13'b0, r_idx, 32'(r_code)};
            r_kind  <= MK_DATA;
            r_state <= ST_MEMWR;
          end else if (!r_pend_vld) begin
            r_pend     <= r_code;
            r_pend_vld <= 1'b1;
            r_state    <= ST_NEXT;
          end else begin
            r_word     <= {32'(r_code), 32'(r_pend)};
            r_pend_vld <= 1'b0;
            r_kind     <= MK_DATA;
            r_state    <= ST_MEMWR;
          end
        end
        ST_MEMWR: begin
          if (EXT_MEM_error) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MEMWAIT;
          end
        end
        ST_MEMWAIT: begin
          if (EXT_MEM_error) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else if (EXT_MEM_writeTxnDone) begin
            r_addr <= r_addr + 32'd8;
            case (r_kind)
              MK_DATA:  r_state <= ST_NEXT;
              MK_FLUSH: r_state <= ST_HEADER;
              default:  r_state <= ST_DONE;
            endcase
          end
        end
        ST_NEXT: begin
          r_idx <= w_idx_nxt;
          if (w_idx_nxt < r_pcsize) begin
            r_state <= ST_READ;
          end else if (r_pend_vld) begin
            // Odd code count: pad the last word so every stored word is full.
            r_word     <= {FLUSH_PAD, 32'(r_pend)};
            r_pend_vld <= 1'b0;
            r_kind     <= MK_FLUSH;
            r_state    <= ST_MEMWR;
          end else begin
            r_state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          r_word  <= {13'b0, r_enc, 13'b0, r_pcsize};
          r_addr  <= HDR_ADDR;
          r_kind  <= MK_HDR;
          r_state <= ST_MEMWR;
        end
        ST_DONE: if (!EXT_enable) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_fog.sv
// Directed and seeded-random bench for ext_fog with point-source, writeback and memory responders.
module tb_ext_fog;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               EXT_enable = 1'b0;
  logic [18:0]        EXT_PCSize = '0;
  logic               EXT_readReady;
  logic [18:0]        EXT_readID;
  logic               EXT_readValid = 1'b0;
  logic signed [15:0] EXT_pointX = '0, EXT_pointY = '0, EXT_pointZ = '0;
  logic               EXT_writeValid;
  logic [18:0]        EXT_writeID;
  logic [15:0]        EXT_writeCustomField;
  logic               EXT_writeReady = 1'b0;
  logic               EXT_doneProcessing;
  logic [31:0]        EXT_status;
  logic [31:0]        EXT_MEM_writeAddress;
  logic [63:0]        EXT_MEM_writePayload;
  logic               EXT_MEM_initWriteTxn;
  logic               EXT_MEM_writeTxnDone = 1'b0;
  logic [31:0]        EXT_MEM_readAddress;
  logic               EXT_MEM_initReadTxn;
  logic               EXT_MEM_error = 1'b0;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;
  bit mem_err_mode = 1'b0;
  int pulse_err = 0;

  logic signed [15:0] px [0:255];
  logic signed [15:0] py [0:255];
  logic signed [15:0] pz [0:255];
  logic [31:0]        exp_code [0:255];

  logic [31:0] mem_addr_q [$];
  logic [63:0] mem_data_q [$];
  logic [18:0] wb_id_q [$];
  logic [15:0] wb_tag_q [$];

  always #5 clk = ~clk;

  ext_fog dut (
    .i_SYSTEM_clk        (clk),
    .i_SYSTEM_rst        (rst),
    .EXT_enable          (EXT_enable),
    .EXT_PCSize          (EXT_PCSize),
    .EXT_readReady       (EXT_readReady),
    .EXT_readID          (EXT_readID),
    .EXT_readValid       (EXT_readValid),
    .EXT_pointX          (EXT_pointX),
    .EXT_pointY          (EXT_pointY),
    .EXT_pointZ          (EXT_pointZ),
    .EXT_readCustomField (16'hA5A5),
    .EXT_writeValid      (EXT_writeValid),
    .EXT_writeID         (EXT_writeID),
    .EXT_writeCustomField(EXT_writeCustomField),
    .EXT_writeReady      (EXT_writeReady),
    .EXT_doneProcessing  (EXT_doneProcessing),
    .EXT_status          (EXT_status),
    .EXT_MEM_writeAddress(EXT_MEM_writeAddress),
    .EXT_MEM_writePayload(EXT_MEM_writePayload),
    .EXT_MEM_initWriteTxn(EXT_MEM_initWriteTxn),
    .EXT_MEM_writeTxnDone(EXT_MEM_writeTxnDone),
    .EXT_MEM_readAddress (EXT_MEM_readAddress),
    .EXT_MEM_initReadTxn (EXT_MEM_initReadTxn),
    .EXT_MEM_readPayload (64'h0),
    .EXT_MEM_readTxnDone (1'b0),
    .EXT_MEM_error       (EXT_MEM_error)
  );

  // Point source: answers each request one cycle later with the stored point.
  initial forever begin
    @(posedge clk); #1;
    if (EXT_readReady) begin
      EXT_pointX = px[EXT_readID[7:0]];
      EXT_pointY = py[EXT_readID[7:0]];
      EXT_pointZ = pz[EXT_readID[7:0]];
      EXT_readValid = 1'b1;
      @(posedge clk); #1;
      EXT_readValid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (EXT_writeValid) begin
      wb_id_q.push_back(EXT_writeID);
      wb_tag_q.push_back(EXT_writeCustomField);
      EXT_writeReady = 1'b1;
      @(posedge clk); #1;
      EXT_writeReady = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (EXT_MEM_initWriteTxn) begin
      mem_addr_q.push_back(EXT_MEM_writeAddress);
      mem_data_q.push_back(EXT_MEM_writePayload);
      if (mem_err_mode) begin
        EXT_MEM_error = 1'b1;
        @(posedge clk); #1;
        EXT_MEM_error = 1'b0;
      end else begin
        repeat (mem_lat) @(posedge clk);
        #1 EXT_MEM_writeTxnDone = 1'b1;
        @(posedge clk); #1;
        EXT_MEM_writeTxnDone = 1'b0;
      end
    end
  end

  logic prev_init = 1'b0;
  initial forever begin
    @(negedge clk);
    if (EXT_MEM_initWriteTxn && prev_init) pulse_err++;
    prev_init = EXT_MEM_initWriteTxn;
  end

  function automatic logic [31:0] morton_ref(input int x, input int y, input int z);
    int cx, cy, cz;
    logic [31:0] c;
    cx = (x + 20000) >> fog_pkg::SHIFT;
    cy = (y + 20000) >> fog_pkg::SHIFT;
    cz = (z + 20000) >> fog_pkg::SHIFT;
    c = 0;
    for (int b = 0; b < 9; b++)
      c = c | (32'((cx >> b) & 1) << (3*b+2)) | (32'((cy >> b) & 1) << (3*b+1)) | (32'((cz >> b) & 1) << (3*b));
    return c;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input int n, input int budget, output bit timed_out);
    mem_addr_q.delete(); mem_data_q.delete(); wb_id_q.delete(); wb_tag_q.delete();
    EXT_PCSize = 19'(n);
    EXT_enable = 1'b1;
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (EXT_doneProcessing) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic set_pt(input int i, input int x, input int y, input int z);
    px[i] = 16'(x); py[i] = 16'(y); pz[i] = 16'(z);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (EXT_readReady !== 1'b0 || EXT_writeValid !== 1'b0 || EXT_MEM_initWriteTxn !== 1'b0) begin
      errors++; $display("FAIL reset_handshakes: got %b%b%b expected 000", EXT_readReady, EXT_writeValid, EXT_MEM_initWriteTxn); end
    checks++; if (EXT_status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", EXT_status); end
    checks++; if (EXT_MEM_writeAddress !== 32'h0 || EXT_MEM_writePayload !== 64'h0) begin
      errors++; $display("FAIL reset_mem: got %h/%h expected 0/0", EXT_MEM_writeAddress, EXT_MEM_writePayload); end
    checks++; if (EXT_doneProcessing !== 1'b0 || EXT_writeCustomField !== 16'h0 || EXT_readID !== 19'h0) begin
      errors++; $display("FAIL reset_misc: got %b %h %h expected 0 0 0", EXT_doneProcessing, EXT_writeCustomField, EXT_readID); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (EXT_status !== 32'h0) begin errors++; $display("FAIL idle_status: got %h expected 0", EXT_status); end
  endtask

  task automatic test_single_point();
    bit to;
    set_pt(0, 0, 0, 0);
    run_frame(1, 300, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got no done expected done"); end
    checks++; if (wb_tag_q.size() !== 1 || wb_tag_q[0] !== 16'h1C0F) begin
      errors++; $display("FAIL single_tag: got n=%0d %h expected n=1 1c0f", wb_tag_q.size(), wb_tag_q[0]); end
    checks++; if (mem_addr_q.size() !== 2) begin errors++; $display("FAIL single_nwr: got %0d expected 2", mem_addr_q.size()); end
    checks++; if (mem_addr_q[0] !== 32'd8 || mem_data_q[0] !== 64'hFFFFFFFF_00E07FC0) begin
      errors++; $display("FAIL single_data: got @%0d %h expected @8 ffffffff00e07fc0", mem_addr_q[0], mem_data_q[0]); end
    checks++; if (mem_addr_q[1] !== 32'd0 || mem_data_q[1] !== 64'h00000001_00000001) begin
      errors++; $display("FAIL single_hdr: got @%0d %h expected @0 0000000100000001", mem_addr_q[1], mem_data_q[1]); end
    checks++; if (EXT_status[3:0] !== 4'h7) begin errors++; $display("FAIL single_status: got %h expected 7", EXT_status[3:0]); end
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (EXT_doneProcessing !== 1'b0 || EXT_status[2:0] !== 3'd0) begin
      errors++; $display("FAIL single_release: got done=%b st=%0d expected 0 0", EXT_doneProcessing, EXT_status[2:0]); end
  endtask

  task automatic test_box_corners();
    bit to;
    set_pt(0, -20000, -20000, -20000);
    set_pt(1, 20000, 20000, 20000);
    run_frame(2, 300, to);
    checks++; if (to) begin errors++; $display("FAIL corner_timeout: got no done expected done"); end
    checks++; if (wb_tag_q.size() !== 2 || wb_tag_q[0] !== 16'h0000 || wb_tag_q[1] !== 16'hE07F) begin
      errors++; $display("FAIL corner_tags: got %h %h expected 0000 e07f", wb_tag_q[0], wb_tag_q[1]); end
    checks++; if (mem_data_q.size() !== 2 || mem_data_q[0] !== 64'h0703FE00_00000000) begin
      errors++; $display("FAIL corner_data: got %h expected 0703fe0000000000", mem_data_q[0]); end
    checks++; if (mem_data_q[1] !== 64'h00000002_00000002) begin
      errors++; $display("FAIL corner_hdr: got %h expected 0000000200000002", mem_data_q[1]); end
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Frame of three points with the middle one outside the box; reused by the back-to-back test.
  task automatic load_skip_frame();
    set_pt(0, 0, 0, 0);
    set_pt(1, 25000, 0, 0);
    set_pt(2, -20000, -20000, -20000);
  endtask

  task automatic test_out_of_box();
    bit to;
    load_skip_frame();
    run_frame(3, 300, to);
    checks++; if (to) begin errors++; $display("FAIL oob_timeout: got no done expected done"); end
    checks++; if (wb_id_q.size() !== 2 || wb_id_q[0] !== 19'd0 || wb_id_q[1] !== 19'd2) begin
      errors++; $display("FAIL oob_wbids: got n=%0d %0d %0d expected n=2 0 2", wb_id_q.size(), wb_id_q[0], wb_id_q[1]); end
    checks++; if (mem_addr_q.size() !== 2 || mem_addr_q[0] !== 32'd8 || mem_addr_q[1] !== 32'd0) begin
      errors++; $display("FAIL oob_addrs: got n=%0d %0d %0d expected n=2 8 0", mem_addr_q.size(), mem_addr_q[0], mem_addr_q[1]); end
    checks++; if (mem_data_q[0] !== 64'h00000000_00E07FC0) begin
      errors++; $display("FAIL oob_data: got %h expected 0000000000e07fc0", mem_data_q[0]); end
    checks++; if (mem_data_q[1] !== 64'h00000002_00000003) begin
      errors++; $display("FAIL oob_hdr: got %h expected 0000000200000003", mem_data_q[1]); end
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_frame();
    bit to;
    int x, y, z;
    for (int i = 0; i < 200; i++) begin
      x = int'($urandom_range(32766)) - 16383;
      y = int'($urandom_range(32766)) - 16383;
      z = int'($urandom_range(32766)) - 16383;
      set_pt(i, x, y, z);
      exp_code[i] = morton_ref(x, y, z);
    end
    mem_lat = 300;
    pulse_err = 0;
    run_frame(200, 45000, to);
    checks++; if (to) begin errors++; $display("FAIL rand_timeout: got no done expected done"); end
    checks++; if (wb_tag_q.size() !== 200) begin errors++; $display("FAIL rand_nwb: got %0d expected 200", wb_tag_q.size()); end
    for (int i = 0; i < 200 && i < wb_tag_q.size(); i++) begin
      checks++; if (wb_tag_q[i] !== 16'(exp_code[i] >> (fog_pkg::CODE_W - 16))) begin
        errors++; $display("FAIL rand_tag[%0d]: got %h expected %h", i, wb_tag_q[i], 16'(exp_code[i] >> (fog_pkg::CODE_W - 16))); end
    end
    checks++; if (mem_addr_q.size() !== 101) begin errors++; $display("FAIL rand_nwr: got %0d expected 101", mem_addr_q.size()); end
    for (int k = 0; k < 100 && k < mem_addr_q.size(); k++) begin
      checks++; if (mem_addr_q[k] !== 32'(8 + 8*k) || mem_data_q[k] !== {exp_code[2*k+1], exp_code[2*k]}) begin
        errors++; $display("FAIL rand_word[%0d]: got @%0d %h expected @%0d %h", k, mem_addr_q[k], mem_data_q[k], 8 + 8*k, {exp_code[2*k+1], exp_code[2*k]}); end
    end
    checks++; if (mem_addr_q[100] !== 32'd0 || mem_data_q[100] !== 64'h000000C8_000000C8) begin
      errors++; $display("FAIL rand_hdr: got @%0d %h expected @0 000000c8000000c8", mem_addr_q[100], mem_data_q[100]); end
    checks++; if (pulse_err !== 0) begin errors++; $display("FAIL rand_pulse: got %0d long pulses expected 0", pulse_err); end
    mem_lat = 2;
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mem_error();
    bit to;
    set_pt(0, 0, 0, 0);
    set_pt(1, 0, 0, 0);
    mem_err_mode = 1'b1;
    run_frame(2, 300, to);
    checks++; if (to) begin errors++; $display("FAIL err_timeout: got no done expected done"); end
    checks++; if (EXT_status[3:0] !== 4'hF) begin errors++; $display("FAIL err_status: got %h expected f", EXT_status[3:0]); end
    repeat (5) @(negedge clk);
    checks++; if (mem_addr_q.size() !== 1 || mem_addr_q[0] !== 32'd8) begin
      errors++; $display("FAIL err_nohdr: got n=%0d first @%0d expected n=1 @8", mem_addr_q.size(), mem_addr_q[0]); end
    mem_err_mode = 1'b0;
    EXT_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (EXT_doneProcessing !== 1'b0) begin errors++; $display("FAIL err_release: got %b expected 0", EXT_doneProcessing); end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int f = 0; f < 14; f++) begin
      pulse_reset();
      load_skip_frame();
      run_frame(3, 300, to);
      checks++; if (to || mem_data_q.size() !== 2 || wb_id_q.size() !== 2) begin
        errors++; $display("FAIL b2b_shape[%0d]: got to=%b nwr=%0d nwb=%0d expected 0 2 2", f, to, mem_data_q.size(), wb_id_q.size()); end
      checks++; if (mem_data_q[0] !== 64'h00000000_00E07FC0 || mem_data_q[1] !== 64'h00000002_00000003) begin
        errors++; $display("FAIL b2b_image[%0d]: got %h %h expected 0000000000e07fc0 0000000200000003", f, mem_data_q[0], mem_data_q[1]); end
      EXT_enable = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (EXT_doneProcessing !== 1'b0) begin errors++; $display("FAIL b2b_release[%0d]: got %b expected 0", f, EXT_doneProcessing); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin px[i] = '0; py[i] = '0; pz[i] = '0; exp_code[i] = '0; end
    test_reset();
    test_single_point();
    test_box_corners();
    test_out_of_box();
    test_random_frame();
    test_mem_error();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
